// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Load/store engine sitting between the register file and the data-memory
// bus. A transaction takes a 16-bit pointer from a register pair, performs a
// single byte-wide read or write over a req/ack handshake (any number of
// wait states), and hands back the load byte plus the updated pointer
// (post-increment or pre-decrement) so it can be written back into the
// same register pair. A missing acknowledge aborts the access after
// TIMEOUT request cycles with err=1.
//
// Parameters:
//   TIMEOUT    maximum number of cycles mem_req stays high without mem_ack
//              before the access is aborted; 0 disables the timeout.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request a transaction (sampled only while busy=0)
//   we         1 = store, 0 = load (sampled with start)
//   mode       pointer update: 00 none, 01 post-inc, 10 pre-dec, 11 none
//   addr       pointer value from the register pair
//   wdata      store byte
//   busy       transaction in progress (CPU stall)
//   done       one-cycle completion pulse
//   err        valid with done; 1 = aborted by timeout
//   rdata      load byte, held until the next successful load
//   ptr_new    updated pointer, valid with done
//   ptr_wr     write-back strobe for ptr_new, pulses with done
//   mem_req    bus request
//   mem_we     bus write strobe
//   mem_addr   bus address
//   mem_wdata  bus write data
//   mem_rdata  bus read data, valid while mem_ack=1
//   mem_ack    bus acknowledge
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [1:0]  mode,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [15:0] ptr_new,
    output logic        ptr_wr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);

    // Wait-state counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FIN
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            we_q;
    logic            upd_q;
    logic            err_q;
    logic [CW-1:0]   wait_cnt;
    logic            timeout_hit;
    logic [15:0]     addr_inc;
    logic [15:0]     addr_dec;
    logic            mode_inc;
    logic            mode_dec;

    // 16-bit modulo pointer arithmetic; wrap-around falls out of the width.
    assign addr_inc    = addr + 16'd1;
    assign addr_dec    = addr - 16'd1;
    assign mode_inc    = (mode == 2'b01);
    assign mode_dec    = (mode == 2'b10);
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. An ack in the same cycle the counter expires takes
    // priority, so a late-but-in-time ack still completes normally.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_ack || timeout_hit) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode. The write strobe is gated by mem_req so the bus never
    // sees a write outside an active request; address and data simply hold.
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        ptr_wr  = 1'b0;
        case (state)
            REQ: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                busy    = 1'b1;
            end
            FIN: begin
                busy   = 1'b1;
                done   = 1'b1;
                err    = err_q;
                ptr_wr = upd_q & ~err_q;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    // Transaction datapath. Everything the bus needs is captured at start so
    // that the register file is free to change while the access is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q      <= 1'b0;
            upd_q     <= 1'b0;
            err_q     <= 1'b0;
            wait_cnt  <= '0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            ptr_new   <= 16'h0000;
            rdata     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        we_q      <= we;
                        upd_q     <= mode_inc | mode_dec;
                        err_q     <= 1'b0;
                        wait_cnt  <= '0;
                        mem_wdata <= wdata;
                        mem_addr  <= mode_dec ? addr_dec : addr;
                        if (mode_inc) begin
                            ptr_new <= addr_inc;
                        end else if (mode_dec) begin
                            ptr_new <= addr_dec;
                        end else begin
                            ptr_new <= addr;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        err_q <= 1'b0;
                        if (!we_q) begin
                            rdata <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else if (TIMEOUT_EN) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    err_q <= err_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit built with TIMEOUT=4. Each scenario
// task drives its own stimulus and compares against a transaction-level
// model: effective address, updated pointer, completion cycle, error flag
// and the held load byte are all worked out from the pointer rules and the
// ack timing, not from the design's internals.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        we;
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  rdata;
    logic [15:0] ptr_new;
    logic        ptr_wr;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int n_checks;
    int n_fail;

    // Reference state: the load byte the unit should currently be holding.
    logic [7:0] model_rdata;

    // Observations gathered by the transaction driver.
    int          obs_req;
    int          obs_done;
    logic        obs_stable;
    logic [15:0] obs_addr;
    logic        obs_we;
    logic [7:0]  obs_wdata;
    logic        obs_err;
    logic        obs_ptr_wr;
    logic [15:0] obs_ptr;
    logic [7:0]  obs_rdata;
    logic [15:0] obs_post_addr;
    logic        obs_post_we;
    logic        obs_busy_after;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .we        (we),
        .mode      (mode),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .ptr_new   (ptr_new),
        .ptr_wr    (ptr_wr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the pointer rules.
    function automatic logic [15:0] model_bus_addr(input logic [15:0] a, input logic [1:0] m);
        return (m == 2'b10) ? 16'(a - 16'd1) : a;
    endfunction

    function automatic logic [15:0] model_ptr(input logic [15:0] a, input logic [1:0] m);
        if (m == 2'b01) return 16'(a + 16'd1);
        if (m == 2'b10) return 16'(a - 16'd1);
        return a;
    endfunction

    // Drives one transaction starting in the current cycle (cycle 0) and
    // records what the bus and completion outputs did. Register-file inputs
    // are scrambled after start to show that the unit latched them. Returns
    // one cycle after done, in the IDLE cycle where a new start is legal.
    task automatic do_txn(input logic t_we, input logic [1:0] t_mode, input logic [15:0] t_addr,
                          input logic [7:0] t_wdata, input int ack_cyc, input logic [7:0] ack_data);
        logic seen;
        seen       = 1'b0;
        obs_req    = 0;
        obs_done   = -1;
        obs_stable = 1'b1;
        obs_addr   = 16'hxxxx;
        obs_we     = 1'bx;
        obs_wdata  = 8'hxx;
        start      = 1'b1;
        we         = t_we;
        mode       = t_mode;
        addr       = t_addr;
        wdata      = t_wdata;
        @(posedge clk); #1;
        start = 1'b0;
        addr  = 16'($urandom);
        wdata = 8'($urandom);
        we    = 1'($urandom);
        mode  = 2'($urandom);
        for (int c = 1; c <= 12; c++) begin
            if (mem_req) begin
                obs_req++;
                if (!seen) begin
                    seen      = 1'b1;
                    obs_addr  = mem_addr;
                    obs_we    = mem_we;
                    obs_wdata = mem_wdata;
                end else if (mem_addr !== obs_addr || mem_we !== obs_we || mem_wdata !== obs_wdata) begin
                    obs_stable = 1'b0;
                end
            end
            if (done) begin
                obs_done      = c;
                obs_err       = err;
                obs_ptr_wr    = ptr_wr;
                obs_ptr       = ptr_new;
                obs_rdata     = rdata;
                obs_post_addr = mem_addr;
                obs_post_we   = mem_we;
                break;
            end
            mem_ack   = (c == ack_cyc);
            mem_rdata = (c == ack_cyc) ? ack_data : 8'($urandom);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        @(posedge clk); #1;
        obs_busy_after = busy;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        we        = 1'b0;
        mode      = 2'b00;
        addr      = 16'h0000;
        wdata     = 8'h00;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        model_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err got %b want 0", err); end
        n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rdata got %h want 00", rdata); end
        n_checks++; if (ptr_new !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_ptr_new got %h want 0000", ptr_new); end
        n_checks++; if (ptr_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ptr_wr got %b want 0", ptr_wr); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req got %b want 0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_we got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_mem_addr got %h want 0000", mem_addr); end
        n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_mem_wdata got %h want 00", mem_wdata); end
    endtask

    task automatic test_load_postinc();
        model_rdata = 8'hA5;
        do_txn(1'b0, 2'b01, 16'h12FF, 8'h00, 3, 8'hA5);
        n_checks++; if (obs_addr !== 16'h12FF) begin n_fail++; $display("[TB] FAIL ld_inc_mem_addr got %h want 12ff", obs_addr); end
        n_checks++; if (obs_we !== 1'b0) begin n_fail++; $display("[TB] FAIL ld_inc_mem_we got %b want 0", obs_we); end
        n_checks++; if (obs_req != 3) begin n_fail++; $display("[TB] FAIL ld_inc_req_cycles got %0d want 3", obs_req); end
        n_checks++; if (obs_done != 4) begin n_fail++; $display("[TB] FAIL ld_inc_done_cycle got %0d want 4", obs_done); end
        n_checks++; if (obs_rdata !== 8'hA5) begin n_fail++; $display("[TB] FAIL ld_inc_rdata got %h want a5", obs_rdata); end
        n_checks++; if (obs_ptr !== 16'h1300) begin n_fail++; $display("[TB] FAIL ld_inc_ptr_new got %h want 1300", obs_ptr); end
        n_checks++; if (obs_ptr_wr !== 1'b1) begin n_fail++; $display("[TB] FAIL ld_inc_ptr_wr got %b want 1", obs_ptr_wr); end
        n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ld_inc_err got %b want 0", obs_err); end
    endtask

    task automatic test_store_predec();
        do_txn(1'b1, 2'b10, 16'h0000, 8'h3C, 1, 8'hEE);
        n_checks++; if (obs_addr !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL st_dec_mem_addr got %h want ffff", obs_addr); end
        n_checks++; if (obs_we !== 1'b1) begin n_fail++; $display("[TB] FAIL st_dec_mem_we got %b want 1", obs_we); end
        n_checks++; if (obs_wdata !== 8'h3C) begin n_fail++; $display("[TB] FAIL st_dec_mem_wdata got %h want 3c", obs_wdata); end
        n_checks++; if (obs_done != 2) begin n_fail++; $display("[TB] FAIL st_dec_done_cycle got %0d want 2", obs_done); end
        n_checks++; if (obs_ptr !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL st_dec_ptr_new got %h want ffff", obs_ptr); end
        n_checks++; if (obs_ptr_wr !== 1'b1) begin n_fail++; $display("[TB] FAIL st_dec_ptr_wr got %b want 1", obs_ptr_wr); end
        n_checks++; if (obs_rdata !== model_rdata) begin n_fail++; $display("[TB] FAIL st_dec_rdata_held got %h want %h", obs_rdata, model_rdata); end
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 2'b01, 16'h4000, 8'h00, 0, 8'h00);
        n_checks++; if (obs_req != TO) begin n_fail++; $display("[TB] FAIL to_req_cycles got %0d want %0d", obs_req, TO); end
        n_checks++; if (obs_done != TO + 1) begin n_fail++; $display("[TB] FAIL to_done_cycle got %0d want %0d", obs_done, TO + 1); end
        n_checks++; if (obs_err !== 1'b1) begin n_fail++; $display("[TB] FAIL to_err got %b want 1", obs_err); end
        n_checks++; if (obs_ptr_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL to_ptr_wr got %b want 0", obs_ptr_wr); end
        n_checks++; if (obs_rdata !== model_rdata) begin n_fail++; $display("[TB] FAIL to_rdata_held got %h want %h", obs_rdata, model_rdata); end
        n_checks++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("[TB] FAIL to_busy_after got %b want 0", obs_busy_after); end
    endtask

    task automatic test_ack_last();
        model_rdata = 8'h77;
        do_txn(1'b0, 2'b00, 16'h5555, 8'h00, TO, 8'h77);
        n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_last_err got %b want 0", obs_err); end
        n_checks++; if (obs_rdata !== 8'h77) begin n_fail++; $display("[TB] FAIL ack_last_rdata got %h want 77", obs_rdata); end
        n_checks++; if (obs_done != TO + 1) begin n_fail++; $display("[TB] FAIL ack_last_done_cycle got %0d want %0d", obs_done, TO + 1); end
        n_checks++; if (obs_ptr_wr !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_last_ptr_wr got %b want 0", obs_ptr_wr); end
    endtask

    // start held high through cycles 1..3 of a request must not queue a
    // second access; a start in the first IDLE cycle after done must win.
    task automatic test_start_ignored();
        int   rises;
        int   addr_bad;
        logic prev_req;
        rises    = 0;
        addr_bad = 0;
        prev_req = 1'b0;
        start = 1'b1; we = 1'b0; mode = 2'b00; addr = 16'hABCD;
        @(posedge clk); #1;
        for (int c = 1; c <= 5; c++) begin
            if (mem_req && !prev_req) rises++;
            if (mem_req && mem_addr !== 16'hABCD) addr_bad++;
            prev_req = mem_req;
            if (c == 4) begin
                n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL ign_done_cycle4 got %b want 1", done); end
            end
            start     = (c <= 3) || (c == 5);
            we        = (c <= 3);
            addr      = (c == 5) ? 16'h0F0F : 16'($urandom);
            mode      = 2'b00;
            mem_ack   = (c == 3);
            mem_rdata = 8'h5A;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        model_rdata = 8'h5A;
        start = 1'b0;
        n_checks++; if (rises != 1) begin n_fail++; $display("[TB] FAIL ign_request_count got %0d want 1", rises); end
        n_checks++; if (addr_bad != 0) begin n_fail++; $display("[TB] FAIL ign_addr_changed got %0d want 0", addr_bad); end
        n_checks++; if (rdata !== 8'h5A) begin n_fail++; $display("[TB] FAIL ign_rdata got %h want 5a", rdata); end
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL ign_next_accept got %b want 1", mem_req); end
        n_checks++; if (mem_addr !== 16'h0F0F) begin n_fail++; $display("[TB] FAIL ign_next_addr got %h want 0f0f", mem_addr); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL ign_next_we got %b want 0", mem_we); end
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        model_rdata = 8'hC3;
        n_checks++; if (done !== 1'b1 || rdata !== 8'hC3) begin n_fail++; $display("[TB] FAIL ign_next_done got done=%b rdata=%h want 1 c3", done, rdata); end
        @(posedge clk); #1;
    endtask

    // Randomised back-to-back transactions compared with the model.
    task automatic test_back_to_back();
        logic        t_we;
        logic [1:0]  t_mode;
        logic [15:0] t_addr;
        logic [7:0]  t_wdata;
        logic [7:0]  t_data;
        int          ack_cyc;
        int          sel;
        logic        exp_err;
        int          exp_done;
        int          exp_req;
        for (int i = 0; i < 40; i++) begin
            t_we    = 1'($urandom);
            t_mode  = 2'($urandom);
            sel     = $urandom_range(0, 3);
            t_addr  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
            t_wdata = 8'($urandom);
            t_data  = 8'($urandom);
            ack_cyc = $urandom_range(0, 6);
            exp_err  = (ack_cyc == 0) || (ack_cyc > TO);
            exp_done = exp_err ? TO + 1 : ack_cyc + 1;
            exp_req  = exp_err ? TO : ack_cyc;
            if (!t_we && !exp_err) model_rdata = t_data;
            do_txn(t_we, t_mode, t_addr, t_wdata, ack_cyc, t_data);
            n_checks++; if (obs_req != exp_req) begin n_fail++; $display("[TB] FAIL rnd%0d_req_cycles got %0d want %0d", i, obs_req, exp_req); end
            n_checks++; if (obs_done != exp_done) begin n_fail++; $display("[TB] FAIL rnd%0d_done_cycle got %0d want %0d", i, obs_done, exp_done); end
            n_checks++; if (obs_err !== exp_err) begin n_fail++; $display("[TB] FAIL rnd%0d_err got %b want %b", i, obs_err, exp_err); end
            n_checks++; if (obs_addr !== model_bus_addr(t_addr, t_mode)) begin n_fail++; $display("[TB] FAIL rnd%0d_mem_addr got %h want %h", i, obs_addr, model_bus_addr(t_addr, t_mode)); end
            n_checks++; if (obs_we !== t_we) begin n_fail++; $display("[TB] FAIL rnd%0d_mem_we got %b want %b", i, obs_we, t_we); end
            if (t_we) begin
                n_checks++; if (obs_wdata !== t_wdata) begin n_fail++; $display("[TB] FAIL rnd%0d_mem_wdata got %h want %h", i, obs_wdata, t_wdata); end
            end
            n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("[TB] FAIL rnd%0d_bus_stable got %b want 1", i, obs_stable); end
            n_checks++; if (obs_ptr_wr !== (!exp_err && (t_mode == 2'b01 || t_mode == 2'b10))) begin n_fail++; $display("[TB] FAIL rnd%0d_ptr_wr got %b mode %b err %b", i, obs_ptr_wr, t_mode, exp_err); end
            if (!exp_err) begin
                n_checks++; if (obs_ptr !== model_ptr(t_addr, t_mode)) begin n_fail++; $display("[TB] FAIL rnd%0d_ptr_new got %h want %h", i, obs_ptr, model_ptr(t_addr, t_mode)); end
            end
            n_checks++; if (obs_rdata !== model_rdata) begin n_fail++; $display("[TB] FAIL rnd%0d_rdata got %h want %h", i, obs_rdata, model_rdata); end
            n_checks++; if (obs_post_we !== 1'b0 || obs_post_addr !== obs_addr) begin n_fail++; $display("[TB] FAIL rnd%0d_bus_hold got we=%b addr=%h want 0 %h", i, obs_post_we, obs_post_addr, obs_addr); end
            n_checks++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd%0d_busy_after got %b want 0", i, obs_busy_after); end
        end
    endtask

    // Reset in cycle 2 of an outstanding request takes effect without a clock.
    task automatic test_reset_mid();
        int late_done;
        int late_req;
        late_done = 0;
        late_req  = 0;
        start = 1'b1; we = 1'b0; mode = 2'b01; addr = 16'h2222;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_pending got %b want 1", mem_req); end
        reset = 1'b1;
        #1;
        model_rdata = 8'h00;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_mem_req got %b want 0", mem_req); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_done got %b want 0", done); end
        n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("[TB] FAIL rstmid_rdata got %h want 00", rdata); end
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (done) late_done++;
            if (mem_req) late_req++;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        n_checks++; if (late_done != 0) begin n_fail++; $display("[TB] FAIL rstmid_late_done got %0d want 0", late_done); end
        n_checks++; if (late_req != 0) begin n_fail++; $display("[TB] FAIL rstmid_late_req got %0d want 0", late_req); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load_postinc();
        test_store_predec();
        test_timeout();
        test_ack_last();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store engine between the CPU's register file and the data-memory bus. It takes a 16-bit pointer from a register pair, plus a store byte, and runs one byte-wide memory transaction over a req/ack handshake with wait states. It returns the load byte and the updated pointer (post-increment or pre-decrement) for write-back into the same register pair. It stalls the CPU through `busy` and aborts with an error when `mem_ack` does not arrive in time.

## Interface
Parameters:
- TIMEOUT, 16: max cycles `mem_req` stays high without `mem_ack` before abort; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a transaction; sampled only while `busy`=0.
- we  in  1  1 = store, 0 = load; sampled with `start`.
- mode  in  2  pointer update: 00 none, 01 post-increment, 10 pre-decrement, 11 treated as 00.
- addr  in  16  pointer value from the register pair.
- wdata  in  8  store byte.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with `done`; 1 = timeout abort.
- rdata  out  8  load byte; held until the next successful load.
- ptr_new  out  16  updated pointer; valid with `done`.
- ptr_wr  out  1  pulse with `done` when mode is 01/10 and `err`=0.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write strobe.
- mem_addr  out  16  bus address.
- mem_wdata  out  8  bus write data.
- mem_rdata  in  8  bus read data; valid when `mem_ack`=1.
- mem_ack  in  1  bus acknowledge.

## Operation
- FSM states: IDLE, REQ, FIN.
- IDLE: `start`=1 latches `we`, `wdata` and the effective address, computes `ptr_new`, clears the timeout counter, then goes to REQ.
  - Effective address: `addr` for modes 00/01/11; `addr`-1 for mode 10.
  - `ptr_new`: `addr`+1 for mode 01; `addr`-1 for mode 10; `addr` otherwise.
  - All pointer arithmetic is 16-bit modulo: FFFF+1=0000, 0000-1=FFFF.
- REQ: `mem_req`=1. `mem_we`, `mem_addr` and `mem_wdata` are driven from the latched values and stay stable the whole time `mem_req` is high.
  - `mem_ack`=1: for a load, capture `mem_rdata` into `rdata`. Deassert `mem_req` the next cycle; go to FIN with err=0.
  - No ack and TIMEOUT≠0: when the counter reaches TIMEOUT-1, go to FIN with err=1. `rdata` is unchanged and `ptr_wr`=0.
  - Otherwise increment the counter and stay in REQ.
- FIN: `done`=1 and `ptr_wr` per the rules above for exactly one cycle, then IDLE.
- `busy`=1 in REQ and FIN.
- `start` while `busy`=1 is ignored, not queued.
- `mem_ack` outside REQ is ignored.
- `mem_req` low: `mem_we`=0; `mem_addr` and `mem_wdata` hold their last values.

## Timing
- Reset values: all outputs 0, including `rdata`=00, `ptr_new`=0000 and `mem_addr`=0000. State is IDLE.
- Reset mid-transaction drops `mem_req` and `busy` immediately (asynchronous). No `done` is issued.
- Cycle 0 `start` -> cycle 1 `mem_req`=1 and `busy`=1.
- Ack in cycle k -> cycle k+1 `done`=1 and `mem_req`=0 -> cycle k+2 IDLE, where a new `start` is accepted.
- Minimum latency is `start` to `done` = 2 cycles, with ack in cycle 1. Back-to-back issue rate is one transaction per 3 cycles.
- Timeout with TIMEOUT=N: `mem_req` is high for exactly N cycles (cycles 1..N). `done`=1 with `err`=1 in cycle N+1.
- Ack arriving in the same cycle the count reaches TIMEOUT-1: the ack wins, giving err=0 and a normal completion.
- `rdata` updates at the edge ending the ack cycle, so it is valid no later than `done`.

## Test plan
- Load with mode 01: addr=12FF, ack in cycle 3, mem_rdata=A5.
  - Required: mem_addr=12FF, mem_we=0.
  - Required in cycle 4: done=1, rdata=A5, ptr_new=1300, ptr_wr=1, err=0.
- Store with mode 10: addr=0000, wdata=3C, ack in cycle 1.
  - Required: mem_addr=FFFF, mem_we=1, mem_wdata=3C.
  - Required in cycle 2: done=1, ptr_new=FFFF, ptr_wr=1.
- Timeout: TIMEOUT=4, load, no ack.
  - Required: mem_req high for cycles 1-4; cycle 5 done=1, err=1, ptr_wr=0; rdata unchanged.
- Ack on the last timeout cycle: TIMEOUT=4, ack in cycle 4 with mem_rdata=77.
  - Required: err=0, rdata=77.
- `start` pulses at cycles 1-3 during a transaction: ignored.
  - Required: exactly one memory request; the next start at cycle k+2 is accepted.
- Reset asserted in cycle 2 of an outstanding request.
  - Required: mem_req, busy, done and rdata all 0 immediately; no done after reset is released.
